// File: rtl/lsu_mem_port.sv
// Load/store memory port: sizes and aligns stores, runs a req/ack handshake, extends loads.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete with ls_err instead of being force-aligned.
module lsu_mem_port #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ls_valid,
    input  logic              ls_write,
    input  logic [2:0]        load_ctrl,
    input  logic [1:0]        store_ctrl,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_stall,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic              ls_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              ls_done_q, ls_done_d;
    logic              ls_err_q, ls_err_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;

    logic [1:0]  req_size;
    logic [1:0]  eff_off;
    logic        illegal;
    logic        misalign;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] rd_shift;
    logic [31:0] load_data;

    // Request decode: size 00 byte, 01 half, 10 word; load funct3[2] selects zero-extension.
    always_comb begin
        req_size = ls_write ? store_ctrl : load_ctrl[1:0];
        illegal  = (req_size == 2'b11) || (!ls_write && load_ctrl[2] && load_ctrl[1]);
        case (req_size)
            2'b00:   eff_off = ls_addr[1:0];
            2'b01:   eff_off = {ls_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
`ifdef MISALIGN_TRAP_EN
        misalign = ((req_size == 2'b01) && ls_addr[0]) ||
                   ((req_size == 2'b10) && (ls_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        case (req_size)
            2'b00: begin
                req_be    = 4'b0001 << eff_off;
                req_wdata = {4{ls_wdata[7:0]}};
            end
            2'b01: begin
                req_be    = 4'b0011 << eff_off;
                req_wdata = {2{ls_wdata[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = ls_wdata;
            end
        endcase
    end

    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_data = uns_q ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = mem_rdata;
        endcase
        if (we_q) load_data = 32'h0;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        uns_d       = uns_q;
        size_d      = size_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        ls_done_d   = 1'b0;
        ls_err_d    = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        case (state_q)
            IDLE: begin
                if (ls_valid) begin
                    we_d        = ls_write;
                    uns_d       = load_ctrl[2];
                    size_d      = req_size;
                    off_d       = eff_off;
                    mem_addr_d  = {ls_addr[ADDR_W-1:2], 2'b00};
                    mem_be_d    = req_be;
                    mem_wdata_d = req_wdata;
                    if (illegal || misalign) begin
                        state_d    = RESP;
                        ls_done_d  = 1'b1;
                        ls_err_d   = 1'b1;
                        ls_rdata_d = 32'h0;
                    end else begin
                        state_d   = REQ;
                        mem_req_d = 1'b1;
                        mem_we_d  = ls_write;
                        cnt_d     = '0;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    ls_done_d  = 1'b1;
                    ls_rdata_d = load_data;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    ls_done_d  = 1'b1;
                    ls_err_d   = 1'b1;
                    ls_rdata_d = 32'h0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            ls_done_q   <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            size_q      <= size_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            ls_done_q   <= ls_done_d;
            ls_err_q    <= ls_err_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign ls_stall  = (state_q == REQ) || ((state_q == IDLE) && ls_valid);
    assign ls_done   = ls_done_q;
    assign ls_err    = ls_err_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: store lanes, load extension, timeout, async reset, illegal/misaligned ops.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid;
    logic        ls_write;
    logic [2:0]  load_ctrl;
    logic [1:0]  store_ctrl;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_stall;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    lsu_mem_port #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ls_valid(ls_valid), .ls_write(ls_write), .load_ctrl(load_ctrl), .store_ctrl(store_ctrl),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_stall(ls_stall), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] lc, input logic [1:0] sc,
                         input logic [31:0] addr, input logic [31:0] wd);
        ls_valid   = 1'b1;
        ls_write   = we;
        load_ctrl  = lc;
        store_ctrl = sc;
        ls_addr    = addr;
        ls_wdata   = wd;
    endtask

    // One transaction acked in its first REQ cycle.
    task automatic run_op(input string tag, input logic we, input logic [2:0] lc, input logic [1:0] sc,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        drive(we, lc, sc, addr, wd);
        #1;
        chk({tag, ".stall_accept"}, {31'h0, ls_stall}, 32'h1);
        step();
        ls_valid = 1'b0;
        chk({tag, ".mem_req"}, {31'h0, mem_req}, 32'h1);
        chk({tag, ".mem_we"}, {31'h0, mem_we}, {31'h0, we});
        chk({tag, ".mem_addr"}, mem_addr, exp_addr);
        chk({tag, ".mem_be"}, {28'h0, mem_be}, {28'h0, exp_be});
        if (we) chk({tag, ".mem_wdata"}, mem_wdata, exp_wd);
        chk({tag, ".stall_req"}, {31'h0, ls_stall}, 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk({tag, ".done"}, {31'h0, ls_done}, 32'h1);
        chk({tag, ".err"}, {31'h0, ls_err}, 32'h0);
        chk({tag, ".rdata"}, ls_rdata, exp_rd);
        chk({tag, ".req_drop"}, {31'h0, mem_req}, 32'h0);
        chk({tag, ".stall_resp"}, {31'h0, ls_stall}, 32'h0);
        step();
        chk({tag, ".done_pulse"}, {31'h0, ls_done}, 32'h0);
        chk({tag, ".rdata_hold"}, ls_rdata, exp_rd);
    endtask

    // Request that must finish in RESP next cycle with an error and no memory request.
    task automatic run_err(input string tag, input logic we, input logic [2:0] lc, input logic [1:0] sc,
                           input logic [31:0] addr);
        drive(we, lc, sc, addr, 32'h0);
        step();
        ls_valid = 1'b0;
        chk({tag, ".done"}, {31'h0, ls_done}, 32'h1);
        chk({tag, ".err"}, {31'h0, ls_err}, 32'h1);
        chk({tag, ".no_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, ".rdata"}, ls_rdata, 32'h0);
        step();
        chk({tag, ".done_pulse"}, {31'h0, ls_done}, 32'h0);
    endtask

    initial begin
        int hi;
        rst_n      = 1'b0;
        ls_valid   = 1'b0;
        ls_write   = 1'b0;
        load_ctrl  = 3'b000;
        store_ctrl = 2'b00;
        ls_addr    = 32'h0;
        ls_wdata   = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst.mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst.ls_done", {31'h0, ls_done}, 32'h0);
        chk("rst.ls_err", {31'h0, ls_err}, 32'h0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        chk("rst.ls_rdata", ls_rdata, 32'h0);
        chk("rst.ls_stall", {31'h0, ls_stall}, 32'h0);
        rst_n = 1'b1;
        step();

        run_op("sw",  1'b1, 3'b000, 2'b10, 32'h104, 32'hDEADBEEF, 32'h0,
               32'h104, 4'b1111, 32'hDEADBEEF, 32'h0);
        run_op("sb",  1'b1, 3'b000, 2'b00, 32'h203, 32'h000000A5, 32'h0,
               32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0);
        run_op("sh",  1'b1, 3'b000, 2'b01, 32'h006, 32'h1234BEEF, 32'h0,
               32'h004, 4'b1100, 32'hBEEFBEEF, 32'h0);
        run_op("lb",  1'b0, 3'b000, 2'b00, 32'h011, 32'h0, 32'h000080FF,
               32'h010, 4'b0010, 32'h0, 32'hFFFFFF80);
        run_op("lbu", 1'b0, 3'b100, 2'b00, 32'h011, 32'h0, 32'h000080FF,
               32'h010, 4'b0010, 32'h0, 32'h00000080);
        run_op("lh",  1'b0, 3'b001, 2'b00, 32'h002, 32'h0, 32'h80011234,
               32'h000, 4'b1100, 32'h0, 32'hFFFF8001);
        run_op("lhu", 1'b0, 3'b101, 2'b00, 32'h002, 32'h0, 32'h80011234,
               32'h000, 4'b1100, 32'h0, 32'h00008001);
        run_op("lw",  1'b0, 3'b010, 2'b00, 32'h008, 32'h0, 32'hCAFEF00D,
               32'h008, 4'b1111, 32'h0, 32'hCAFEF00D);

        // No ack: request stays up for the full timeout window, then errors out.
        drive(1'b0, 3'b000, 2'b00, 32'h20, 32'h0);
        step();
        ls_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            if (mem_req) hi++;
            step();
        end
        chk("to.req_cycles", hi, 32'd16);
        chk("to.req_drop", {31'h0, mem_req}, 32'h0);
        chk("to.done", {31'h0, ls_done}, 32'h1);
        chk("to.err", {31'h0, ls_err}, 32'h1);
        chk("to.rdata", ls_rdata, 32'h0);
        step();
        chk("to.done_pulse", {31'h0, ls_done}, 32'h0);

        // Asynchronous reset while a request is outstanding.
        drive(1'b0, 3'b010, 2'b00, 32'h40, 32'h0);
        step();
        ls_valid = 1'b0;
        chk("arst.req_before", {31'h0, mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.req_now", {31'h0, mem_req}, 32'h0);
        chk("arst.addr_now", mem_addr, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst.req_after", {31'h0, mem_req}, 32'h0);
        chk("arst.done_after", {31'h0, ls_done}, 32'h0);
        run_op("lw_post_rst", 1'b0, 3'b010, 2'b00, 32'h044, 32'h0, 32'h11223344,
               32'h044, 4'b1111, 32'h0, 32'h11223344);

`ifdef MISALIGN_TRAP_EN
        run_err("lw_mis", 1'b0, 3'b010, 2'b00, 32'h006);
        run_err("sh_mis", 1'b1, 3'b000, 2'b01, 32'h101);
`else
        run_op("lw_mis", 1'b0, 3'b010, 2'b00, 32'h006, 32'h0, 32'h55667788,
               32'h004, 4'b1111, 32'h0, 32'h55667788);
        run_op("lhu_mis", 1'b0, 3'b101, 2'b00, 32'h003, 32'h0, 32'hA1B2C3D4,
               32'h000, 4'b1100, 32'h0, 32'h0000A1B2);
`endif
        run_err("ld_011", 1'b0, 3'b011, 2'b00, 32'h008);
        run_err("ld_110", 1'b0, 3'b110, 2'b00, 32'h008);
        run_err("st_11",  1'b1, 3'b000, 2'b11, 32'h008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
